// File: rtl/gpio_in_debounce_pkg.sv
// Shared types and helpers for the GPIO input debounce stage.
package gpio_in_debounce_pkg;

  // GPIO width shared with the Wishbone GPIO slave's gpio_i port.
  localparam int GPIO_WIDTH = 4;

  // Per-bit filter state: IDLE tracks the accepted level, PEND times a candidate change.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } db_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: two-flop synchronizer, tick-counted debounce FSM,
// registered rise/fall pulses aligned with the first cycle of the new level.
module gpio_debounce_bit
  import gpio_in_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  input  logic tick,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = clog2_min1(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchronizer; only sync2_q is allowed to reach the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking, so sync2_q takes the previous sync1_q and both flops really exist.
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter next state: a returning input beats everything; counting advances only on ticks.
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q != lvl_q) begin
          state_d = ST_PEND;
          cnt_d   = '0;
        end
      end
      ST_PEND: begin
        if (sync2_q == lvl_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            lvl_d   = ~lvl_q;
            rise_d  = ~lvl_q;
            fall_d  = lvl_q;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Filter state, accepted level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: shared free-running sample-tick prescaler feeding
// WIDTH independent synchronize-and-debounce bit filters.
module gpio_in_debounce
  import gpio_in_debounce_pkg::*;
#(
  parameter int WIDTH        = GPIO_WIDTH,
  parameter int PRESCALE     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int               PRE_W    = clog2_min1(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("gpio_in_debounce: PRESCALE must be >= 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("gpio_in_debounce: STABLE_TICKS must be >= 1");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  // With PRESCALE=1 the counter stays at 0 == PRE_LAST, so tick is constantly high.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  // Free-running prescaler; bit activity never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (pins_i[i]),
      .tick   (tick),
      .level_o(gpio_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule
